// File: rtl/ucode_pkg.sv
// ucode_pkg: sequencer bit positions, datapath control flags and the default microcode image
package ucode_pkg;
  localparam int SEQ_NEXT = 1;
  localparam int SEQ_END = 2;
  localparam int SEQ_COND = 3;
  localparam int SEQ_WAIT = 4;
  localparam int DEF_CTRL_W = 32;
  typedef enum logic [3:0] {
    DP_PC_WE, DP_PC_INC, DP_IR_WE, DP_MEM_RD, DP_MEM_WR, DP_RF_WE,
    DP_A_WE, DP_B_WE, DP_ALU_ADD, DP_ALU_SUB, DP_CSR_WE
  } dp_flag_e;
  localparam logic [DEF_CTRL_W-1:0] FETCH_WORD = (32'(1) << (DEF_CTRL_W - SEQ_NEXT))
    | (32'(1) << int'(DP_MEM_RD)) | (32'(1) << int'(DP_IR_WE)) | (32'(1) << int'(DP_PC_INC));
  function automatic logic [DEF_CTRL_W-1:0] default_word(input int unsigned step);
    return step == 0 ? FETCH_WORD : step == 1 ? 32'(1) << (DEF_CTRL_W - SEQ_END) : '0;
  endfunction
endpackage

// File: rtl/ucode_sequencer_if.sv
// ucode_sequencer_if: core-side control/status bundle of the microcode sequencer
interface ucode_sequencer_if #(
  parameter int CTRL_W = 32,
  parameter int OP_W = 5,
  parameter int MAX_STEPS = 8,
  parameter int CNT_W = 64
);
  localparam int STEP_W = $clog2(MAX_STEPS);
  logic [OP_W-1:0] opcode;
  logic cond, mem_ready, trap, irq, ucode_we;
  logic [OP_W+STEP_W-1:0] ucode_addr;
  logic [CTRL_W-1:0] ucode_wdata, ctrl;
  logic [STEP_W-1:0] step;
  logic trap_taken, irq_taken, step_ovf;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  modport master (
    output opcode, cond, mem_ready, trap, irq, ucode_we, ucode_addr, ucode_wdata,
    input ctrl, step, trap_taken, irq_taken, step_ovf, cycle_cnt, instret_cnt
  );
  modport slave (
    input opcode, cond, mem_ready, trap, irq, ucode_we, ucode_addr, ucode_wdata,
    output ctrl, step, trap_taken, irq_taken, step_ovf, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/ucode_ram.sv
// ucode_ram: 1W/1R microcode store; asynchronous read so a posedge write is seen by the next negedge read
module ucode_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: walks {opcode, step} through the microcode table with stall, trap/irq entry and counters
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int OP_W = 5,
  parameter int MAX_STEPS = 8,
  parameter int CNT_W = 64
) (
  input logic clk,
  input logic reset,
  ucode_sequencer_if.slave bus
);
  localparam int STEP_W = $clog2(MAX_STEPS);
  logic [CTRL_W-1:0] rdata;
  logic [STEP_W-1:0] step_inc;
  logic fetch_irq, stall, redirect;
  ucode_ram #(.AW(OP_W + STEP_W), .DW(CTRL_W)) u_ram (
    .clk(clk),
    .we(bus.ucode_we),
    .waddr(bus.ucode_addr),
    .wdata(bus.ucode_wdata),
    .raddr({bus.opcode, bus.step}),
    .rdata(rdata)
  );
  always_comb begin
    step_inc = bus.step + STEP_W'(1);
    stall = bus.ctrl[CTRL_W-SEQ_WAIT] && !bus.mem_ready;
    fetch_irq = bus.irq && bus.step == '0 && |bus.ctrl;
    redirect = bus.trap_taken || bus.irq_taken || bus.step_ovf;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.step <= '0;
      bus.trap_taken <= 1'b0;
      bus.irq_taken <= 1'b0;
      bus.step_ovf <= 1'b0;
      bus.cycle_cnt <= '0;
      bus.instret_cnt <= '0;
    end else begin
      bus.trap_taken <= 1'b0;
      bus.irq_taken <= 1'b0;
      bus.step_ovf <= 1'b0;
      bus.cycle_cnt <= bus.cycle_cnt + CNT_W'(1);
      if (bus.trap) begin
        bus.step <= '0;
        bus.trap_taken <= 1'b1;
      end else if (fetch_irq) begin
        bus.irq_taken <= 1'b1;
      end else if (!stall) begin
        if (bus.ctrl[CTRL_W-SEQ_COND]) begin
          bus.step <= bus.cond ? step_inc : '0;
          bus.instret_cnt <= bus.instret_cnt + CNT_W'(!bus.cond);
        end else if (bus.ctrl[CTRL_W-SEQ_END]) begin
          bus.step <= '0;
          bus.instret_cnt <= bus.instret_cnt + CNT_W'(1);
        end else if (bus.ctrl[CTRL_W-SEQ_NEXT]) begin
          bus.step <= step_inc;
          bus.step_ovf <= &bus.step;
        end
      end
    end
  // the word after any redirect is squashed so the datapath never acts on a stale microword
  always_ff @(negedge clk or posedge reset)
    if (reset) bus.ctrl <= '0;
    else bus.ctrl <= redirect ? '0 : rdata;
endmodule
